// File: rtl/input_map_pkg.sv
// Shared button indices, PS/2 scancodes and key-state type for the arcade input mapper.
package input_map_pkg;

    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_FIRE  = 4;
    localparam int BTN_START = 5;
    localparam int BTN_COIN  = 6;
    localparam int BTN_W     = 7;

    localparam logic [7:0] SC_P0_UP      = 8'h75;
    localparam logic [7:0] SC_P0_DOWN    = 8'h72;
    localparam logic [7:0] SC_P0_LEFT    = 8'h6B;
    localparam logic [7:0] SC_P0_RIGHT   = 8'h74;
    localparam logic [7:0] SC_P0_FIRE_A  = 8'h29;
    localparam logic [7:0] SC_P0_FIRE_B  = 8'h14;
    localparam logic [7:0] SC_P0_START_A = 8'h16;
    localparam logic [7:0] SC_P0_START_B = 8'h05;
    localparam logic [7:0] SC_P0_COIN    = 8'h2E;

    localparam logic [7:0] SC_P1_UP      = 8'h2D;
    localparam logic [7:0] SC_P1_DOWN    = 8'h2B;
    localparam logic [7:0] SC_P1_LEFT    = 8'h23;
    localparam logic [7:0] SC_P1_RIGHT   = 8'h34;
    localparam logic [7:0] SC_P1_FIRE    = 8'h1C;
    localparam logic [7:0] SC_P1_START_A = 8'h1E;
    localparam logic [7:0] SC_P1_START_B = 8'h06;
    localparam logic [7:0] SC_P1_COIN    = 8'h36;

    // Field order matches btn_out bit order so the struct packs directly onto a player slice.
    typedef struct packed {
        logic coin;
        logic start;
        logic fire;
        logic up;
        logic down;
        logic left;
        logic right;
    } key_state_t;

    function automatic key_state_t key_mask(input int player, input logic [7:0] sc);
        logic [BTN_W-1:0] v;
        v = '0;
        if (player == 0) begin
            v[BTN_UP]    = (sc == SC_P0_UP);
            v[BTN_DOWN]  = (sc == SC_P0_DOWN);
            v[BTN_LEFT]  = (sc == SC_P0_LEFT);
            v[BTN_RIGHT] = (sc == SC_P0_RIGHT);
            v[BTN_FIRE]  = (sc == SC_P0_FIRE_A) || (sc == SC_P0_FIRE_B);
            v[BTN_START] = (sc == SC_P0_START_A) || (sc == SC_P0_START_B);
            v[BTN_COIN]  = (sc == SC_P0_COIN);
        end else if (player == 1) begin
            v[BTN_UP]    = (sc == SC_P1_UP);
            v[BTN_DOWN]  = (sc == SC_P1_DOWN);
            v[BTN_LEFT]  = (sc == SC_P1_LEFT);
            v[BTN_RIGHT] = (sc == SC_P1_RIGHT);
            v[BTN_FIRE]  = (sc == SC_P1_FIRE);
            v[BTN_START] = (sc == SC_P1_START_A) || (sc == SC_P1_START_B);
            v[BTN_COIN]  = (sc == SC_P1_COIN);
        end
        return key_state_t'(v);
    endfunction

endpackage

// File: rtl/coin_pulse_stretcher.sv
// Stretches a coin source to at least PULSE_CYC cycles; a source high
// across reset must fall and rise again before it counts.
module coin_pulse_stretcher #(
    parameter int PULSE_CYC = 40000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic src_i,
    output logic pulse_o
);

    localparam logic [19:0] CNT_INIT = 20'(PULSE_CYC - 1);

    logic        src_q, src_d;
    logic        lvl_q, lvl_d;
    logic [19:0] cnt_q, cnt_d;
    logic        pulse_q, pulse_d;
    logic        rise;

    always_comb begin
        rise  = src_i & ~src_q;
        src_d = src_i;
        lvl_d = src_i & (lvl_q | rise);
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 20'd1;
        end else if (rise) begin
            cnt_d = CNT_INIT;
        end
        pulse_d = lvl_d | (cnt_q != '0);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            src_q   <= 1'b1;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            src_q   <= src_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 key states with joystick words into per-player buttons.
// Optional autofire is built when INPUT_AUTOFIRE_EN is defined.
module arcade_input_mapper #(
    parameter int NPLAYERS       = 2,
    parameter int COIN_PULSE_CYC = 40000,
    parameter int AUTOFIRE_DIV   = 2000000
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic [10:0]             ps2_key,
    input  logic [16*NPLAYERS-1:0]  joy_in,
`ifdef INPUT_AUTOFIRE_EN
    input  logic [NPLAYERS-1:0]     autofire_en,
`endif
    output logic [7*NPLAYERS-1:0]   btn_out,
    output logic                    key_event
);

    import input_map_pkg::*;

    logic       tog_q, tog_d;
    logic       key_event_q, key_event_d;
    key_state_t ks_q [NPLAYERS];
    key_state_t ks_d [NPLAYERS];
    key_state_t m;
    logic       ev;

    always_comb begin
        ev          = ps2_key[10] ^ tog_q;
        tog_d       = ps2_key[10];
        key_event_d = 1'b0;
        m           = '0;
        for (int p = 0; p < NPLAYERS; p++) begin
            ks_d[p] = ks_q[p];
            m       = key_mask(p, ps2_key[7:0]);
            if (ev && (m != '0)) begin
                key_event_d = 1'b1;
                ks_d[p]     = (ks_q[p] & ~m) | (m & {BTN_W{ps2_key[9]}});
            end
        end
    end

    // History loads during reset so a toggle held across reset is not an event.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            tog_q       <= ps2_key[10];
            key_event_q <= 1'b0;
            for (int p = 0; p < NPLAYERS; p++) ks_q[p] <= '0;
        end else begin
            tog_q       <= tog_d;
            key_event_q <= key_event_d;
            ks_q        <= ks_d;
        end
    end

    assign key_event = key_event_q;

    for (genvar p = 0; p < NPLAYERS; p++) begin : g_pl
        logic [BTN_W-1:0] src;
        logic             coin;
        logic             fire;
        logic [5:0]       btn_q, btn_d;

        assign src = ks_q[p] | joy_in[16*p +: BTN_W];

        coin_pulse_stretcher #(
            .PULSE_CYC (COIN_PULSE_CYC)
        ) u_coin (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .src_i   (src[BTN_COIN]),
            .pulse_o (coin)
        );

`ifdef INPUT_AUTOFIRE_EN
        localparam logic [23:0] AF_LAST = 24'(AUTOFIRE_DIV - 1);

        logic        act_q, act_d;
        logic        ph_q, ph_d;
        logic [23:0] cnt_q, cnt_d;

        always_comb begin
            act_d = src[BTN_FIRE];
            ph_d  = ph_q;
            cnt_d = cnt_q;
            if (!src[BTN_FIRE]) begin
                ph_d  = 1'b0;
                cnt_d = '0;
            end else if (!act_q) begin
                ph_d  = 1'b1;
                cnt_d = '0;
            end else if (cnt_q == AF_LAST) begin
                ph_d  = ~ph_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 24'd1;
            end
            fire = autofire_en[p] ? ph_d : src[BTN_FIRE];
        end

        always_ff @(posedge clk_sys) begin
            if (!reset_n) begin
                act_q <= 1'b0;
                ph_q  <= 1'b0;
                cnt_q <= '0;
            end else begin
                act_q <= act_d;
                ph_q  <= ph_d;
                cnt_q <= cnt_d;
            end
        end
`else
        assign fire = src[BTN_FIRE];
`endif

        always_comb begin
            btn_d           = src[5:0];
            btn_d[BTN_FIRE] = fire;
        end

        always_ff @(posedge clk_sys) begin
            if (!reset_n) btn_q <= '0;
            else          btn_q <= btn_d;
        end

        assign btn_out[7*p +: 7] = {coin, btn_q};
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed plus randomized bench for arcade_input_mapper against a cycle-time reference model.
module tb_arcade_input_mapper;

    localparam int NP = 2;
    localparam int CP = 10;
    localparam int AD = 4;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic [10:0]   ps2_key = '0;
    logic [31:0]   joy_in  = '0;
    logic [13:0]   btn_out;
    logic          key_event;
`ifdef INPUT_AUTOFIRE_EN
    logic [NP-1:0] autofire_en = '0;
`endif

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(
        .NPLAYERS       (NP),
        .COIN_PULSE_CYC (CP),
        .AUTOFIRE_DIV   (AD)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_key     (ps2_key),
        .joy_in      (joy_in),
`ifdef INPUT_AUTOFIRE_EN
        .autofire_en (autofire_en),
`endif
        .btn_out     (btn_out),
        .key_event   (key_event)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state, expressed in elapsed cycles.
    bit kb [NP][7];
    bit m_tog;
    int cyc = 0;
    int rise_t [NP];
    bit qual [NP];
    bit prev_src [NP];
    int fire_t [NP];
    bit fire_prev [NP];

    function automatic bit kmap(input logic [7:0] sc, output int pl, output int b);
        pl = 0;
        b  = 0;
        case (sc)
            8'h75: b = 3;
            8'h72: b = 2;
            8'h6B: b = 1;
            8'h74: b = 0;
            8'h29, 8'h14: b = 4;
            8'h16, 8'h05: b = 5;
            8'h2E: b = 6;
            8'h2D: begin pl = 1; b = 3; end
            8'h2B: begin pl = 1; b = 2; end
            8'h23: begin pl = 1; b = 1; end
            8'h34: begin pl = 1; b = 0; end
            8'h1C: begin pl = 1; b = 4; end
            8'h1E, 8'h06: begin pl = 1; b = 5; end
            8'h36: begin pl = 1; b = 6; end
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            for (int b = 0; b < 7; b++) kb[p][b] = 1'b0;
            rise_t[p]    = -1000;
            qual[p]      = 1'b0;
            prev_src[p]  = 1'b1;
            fire_prev[p] = 1'b0;
            fire_t[p]    = 0;
        end
        m_tog = ps2_key[10];
    endtask

    // One clock: predict from current inputs, clock, compare, then commit key events.
    task automatic step();
        logic [13:0] exp_btn;
        bit          exp_ev;
        bit          src;
        bit          upd;
        int          pl;
        int          b;
        exp_btn = '0;
        exp_ev  = 1'b0;
        upd     = 1'b0;
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < 7; k++) begin
                src = kb[p][k] | joy_in[16*p+k];
                if (k == 6) begin
                    if (src && !prev_src[p]) begin
                        if (cyc - rise_t[p] >= CP) rise_t[p] = cyc;
                        qual[p] = 1'b1;
                    end
                    if (!src) qual[p] = 1'b0;
                    prev_src[p] = src;
                    exp_btn[7*p+k] = qual[p] || (cyc - rise_t[p] < CP);
                end else if (k == 4) begin
                    if (src && !fire_prev[p]) fire_t[p] = cyc;
                    fire_prev[p] = src;
                    exp_btn[7*p+k] = src;
`ifdef INPUT_AUTOFIRE_EN
                    if (autofire_en[p] && src)
                        exp_btn[7*p+k] = (((cyc - fire_t[p]) / AD) % 2) == 0;
`endif
                end else begin
                    exp_btn[7*p+k] = src;
                end
            end
        end
        if (ps2_key[10] != m_tog) begin
            if (kmap(ps2_key[7:0], pl, b) && pl < NP) begin
                exp_ev = 1'b1;
                upd    = 1'b1;
            end
        end
        m_tog = ps2_key[10];
        @(posedge clk_sys);
        #1;
        cyc++;
        check("btn_out", 32'(btn_out), 32'(exp_btn));
        check("key_event", 32'(key_event), 32'(exp_ev));
        if (upd) kb[pl][b] = ps2_key[9];
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
            cyc++;
            check("reset_btn", 32'(btn_out), 32'h0);
            check("reset_kev", 32'(key_event), 32'h0);
        end
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic key(input bit pressed, input bit ext, input logic [7:0] sc);
        ps2_key = {~ps2_key[10], pressed, ext, sc};
        step();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int           hi;
    logic [13:0]  snap;
    logic [7:0]   codes [12];

    initial begin
        codes = '{8'h29, 8'h14, 8'h75, 8'h6B, 8'h2E, 8'h16,
                  8'h2D, 8'h34, 8'h1C, 8'h36, 8'h40, 8'h0E};
        model_reset();
        do_reset(3);
        steps(2);

        key(1'b1, 1'b0, 8'h29);
        check("fire_lat1", 32'(btn_out[4]), 32'h0);
        step();
        check("fire_lat2", 32'(btn_out[4]), 32'h1);
        steps(2);
        key(1'b0, 1'b0, 8'h29);
        steps(3);
        check("fire_rel", 32'(btn_out[4]), 32'h0);

        key(1'b1, 1'b1, 8'h75);
        key(1'b1, 1'b0, 8'h2D);
        steps(2);
        check("up_both", 32'({btn_out[10], btn_out[3]}), 32'h3);
        key(1'b0, 1'b1, 8'h75);
        key(1'b0, 1'b0, 8'h2D);
        steps(2);

        joy_in[19] = 1'b1;
        step();
        joy_in[19] = 1'b0;
        steps(3);
        joy_in[22] = 1'b1;
        hi = 0;
        step();
        joy_in[22] = 1'b0;
        hi += int'(btn_out[13]);
        for (int i = 0; i < 15; i++) begin step(); hi += int'(btn_out[13]); end
        check("coin_min_width", 32'(hi), 32'd10);

        joy_in[6] = 1'b1;
        hi = 0;
        for (int i = 0; i < 25; i++) begin step(); hi += int'(btn_out[6]); end
        joy_in[6] = 1'b0;
        for (int i = 0; i < 15; i++) begin step(); hi += int'(btn_out[6]); end
        check("coin_held_width", 32'(hi), 32'd25);

        hi = 0;
        for (int i = 0; i < 20; i++) begin
            joy_in[6] = (i == 0) || (i == 5);
            step();
            hi += int'(btn_out[6]);
        end
        joy_in[6] = 1'b0;
        check("coin_no_restart", 32'(hi), 32'd10);

        joy_in[4] = 1'b1;
        key(1'b1, 1'b0, 8'h29);
        step();
        joy_in[4] = 1'b0;
        steps(2);
        check("fire_or_glitch", 32'(btn_out[4]), 32'h1);
        key(1'b0, 1'b0, 8'h29);
        steps(2);

        if (ps2_key[10]) key(1'b1, 1'b0, 8'h05);
        key(1'b1, 1'b0, 8'h16);
        joy_in[22] = 1'b1;
        do_reset(3);
        steps(3);
        joy_in[22] = 1'b0;
        steps(2);
        joy_in[22] = 1'b1;
        steps(3);
        check("coin_after_reset", 32'(btn_out[13]), 32'h1);
        joy_in[22] = 1'b0;
        steps(12);

        snap = btn_out;
        key(1'b1, 1'b0, 8'h40);
        key(1'b1, 1'b0, 8'h0E);
        steps(2);
        check("unmapped_btn", 32'(btn_out), 32'(snap));

`ifdef INPUT_AUTOFIRE_EN
        autofire_en = 2'b01;
        joy_in[4]   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("autofire", 32'(btn_out[4]), 32'(((i / AD) % 2) == 0));
        end
        joy_in[4] = 1'b0;
        step();
        check("autofire_rel", 32'(btn_out[4]), 32'h0);
`endif

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                ps2_key = {~ps2_key[10], 1'($urandom), 1'($urandom),
                           codes[$urandom_range(0, 11)]};
            end
            if ($urandom_range(0, 3) == 0) begin
                joy_in[$urandom_range(0, 6)]  = 1'($urandom);
                joy_in[$urandom_range(16, 22)] = 1'($urandom);
                joy_in[31:23] = 9'($urandom);
            end
`ifdef INPUT_AUTOFIRE_EN
            if ($urandom_range(0, 40) == 0) autofire_en = 2'($urandom);
`endif
            if (i == 300) do_reset(2);
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arcade_input_mapper.md
ARCADE_INPUT_MAPPER -- requirements
Module: arcade_input_mapper

Interface
REQ-001 SHALL have parameter NPLAYERS, default 2, number of player channels (legal 1..4).
REQ-002 SHALL have parameter COIN_PULSE_CYC, default 40000, minimum coin output width in clk_sys cycles (legal 1..2^20-1).
REQ-003 SHALL have parameter AUTOFIRE_DIV, default 2000000, autofire half-period in cycles (legal 1..2^24-1).
REQ-004 clk_sys  input  1  system clock; the only clock.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 ps2_key  input  11  keyboard event: [10] toggles per event, [9] pressed, [8] extended, [7:0] scancode.
REQ-007 joy_in  input  16*NPLAYERS  per-player joystick words, player p at [16p+15:16p].
REQ-008 btn_out  output  7*NPLAYERS  per-player controls, player p at [7p+6:7p]; bits [0]right [1]left [2]down [3]up [4]fire [5]start [6]coin.
REQ-009 key_event  output  1  one-cycle pulse when a mapped key event is decoded.

Function
REQ-010 SHALL detect a keyboard event when ps2_key[10] differs from its value registered on the previous cycle.
REQ-011 SHALL, on an event, set the matching key-state bit to ps2_key[9] in the cycle after detection; unmapped codes change nothing and raise no key_event.
REQ-012 Player 0 keys SHALL be: arrows E075/E072/E06B/E074 (extended bit ignored), fire 0x29 or 0x14, start 0x16 or 0x05, coin 0x2E.
REQ-013 Player 1 keys SHALL be: up 0x2D, down 0x2B, left 0x23, right 0x34, fire 0x1C, start 0x1E or 0x06, coin 0x36; players 2-3 have joystick only.
REQ-014 Each source bit SHALL be key-state OR joy_in[16p+b] (b=0..6); btn_out SHALL be registered with 1-cycle latency from joy_in and 2-cycle latency from the ps2_key toggle.
REQ-015 Coin output SHALL rise on the source rising edge and stay high for max(source high time, COIN_PULSE_CYC cycles).
REQ-016 A new coin edge during an active pulse SHALL NOT restart the counter; a held source only extends the pulse.
REQ-017 A player's keyboard and joystick asserting the same bit SHALL produce one OR'd level with no glitch when one releases.

Reset
REQ-018 While reset_n=0 at a clk_sys edge: all key states, coin counters, autofire state, btn_out and key_event SHALL clear to 0.
REQ-019 The ps2_key[10] history register SHALL load the current ps2_key[10] during reset, so no spurious event fires after release.
REQ-020 Reset mid-coin-pulse SHALL abort the pulse; the source must then fall and rise again before a new pulse starts.

Configuration
REQ-021 With macro INPUT_AUTOFIRE_EN defined: add input autofire_en[NPLAYERS-1:0]; when set and fire held, fire output SHALL be high on the first output cycle, then toggle every AUTOFIRE_DIV cycles until release, which drops it next cycle.
REQ-022 Without INPUT_AUTOFIRE_EN: the autofire_en port and counters SHALL be absent, and fire SHALL pass through per REQ-014.

Structure
REQ-023 Package input_map_pkg SHALL hold the btn_out bit-index constants, all scancode constants and the per-player key-state struct typedef.
REQ-024 Coin shaping SHALL be a sub-module coin_pulse_stretcher, instantiated once per player.

Verification
REQ-025 ps2_key toggle with pressed=1, code 0x029 -> btn_out[4]=1 two cycles later and key_event pulses once; release event -> 0 two cycles later.
REQ-026 joy_in[16+3] pulsed 1 cycle, COIN_PULSE_CYC=10 -> btn_out[13]... no coin; joy_in[16+6] pulsed 1 cycle -> btn_out[13]=1 for exactly 10 cycles.
REQ-027 Coin held 25 cycles with COIN_PULSE_CYC=10 -> coin high 25 cycles; second edge at cycle 5 of a 10-cycle pulse -> total still 10 cycles.
REQ-028 reset_n low for 3 cycles while ps2_key[10]=1 and key pressed -> all outputs 0, no key_event after release.
REQ-029 INPUT_AUTOFIRE_EN, AUTOFIRE_DIV=4, autofire_en=1, fire held 20 cycles -> fire pattern 1111 0000 1111..., 0 the cycle after release.
REQ-030 Unmapped code 0x0E40 toggle -> btn_out unchanged, key_event stays 0.
